// File: rtl/pando_tagger_pkg.sv
// Shared definitions for photon_event_tagger: widths, entry field offsets, channel states, clog2.
package pando_tagger_pkg;

    localparam int TS_WIDTH_DEF   = 64;
    localparam int DROP_CNT_WIDTH = 16;
    localparam int ENTRY_TS_LSB   = 0;

    typedef enum logic {
        CH_READY   = 1'b0,
        CH_HOLDOFF = 1'b1
    } ch_state_t;

    // FIFO entries are packed {mask, timestamp}; the mask sits directly above the timestamp.
    function automatic int entry_mask_lsb(input int ts_width);
        return ENTRY_TS_LSB + ts_width;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/tag_sync_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rd_data whenever level is non-zero.
module tag_sync_fifo
    import pando_tagger_pkg::*;
#(
    parameter int WIDTH = 68,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign do_rd = rd_en && (level != '0);
    // When full, a write is only accepted if the same edge frees the head slot.
    assign do_wr = wr_en && ((level != FULL_LEVEL) || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/photon_event_tagger.sv
// Synchronises detector inputs, tags rising edges with the timestamp and buffers them for the packetiser.
// Optional per-channel holdoff is built when TAGGER_DEADTIME_EN is defined.
//
// state      | meaning
// CH_READY   | channel accepts the next qualified edge
// CH_HOLDOFF | channel masked until its down-counter expires
module photon_event_tagger
    import pando_tagger_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int TS_WIDTH        = TS_WIDTH_DEF,
    parameter int FIFO_DEPTH      = 16,
    parameter int DEADTIME_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [TS_WIDTH-1:0]        timestamp,
    input  logic [NUM_CHANNELS-1:0]    det_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_CHANNELS-1:0]    m_mask,
    output logic [TS_WIDTH-1:0]        m_timestamp,
    output logic [clog2(FIFO_DEPTH):0] fifo_level,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count
);

    localparam int LW       = clog2(FIFO_DEPTH) + 1;
    localparam int EW       = NUM_CHANNELS + TS_WIDTH;
    localparam int MASK_LSB = entry_mask_lsb(TS_WIDTH);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
        $error("photon_event_tagger: NUM_CHANNELS must be 1..8");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("photon_event_tagger: FIFO_DEPTH must be a power of two >= 4");
    end
    if (DEADTIME_CYCLES < 1) begin : g_bad_deadtime
        $error("photon_event_tagger: DEADTIME_CYCLES must be >= 1");
    end

    logic [NUM_CHANNELS-1:0] s1;
    logic [NUM_CHANNELS-1:0] s2;
    logic [NUM_CHANNELS-1:0] s3;
    logic [NUM_CHANNELS-1:0] hit_q;
    logic [NUM_CHANNELS-1:0] hit;
    logic                    run_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            hit_q <= '0;
            run_q <= 1'b0;
        end else begin
            s1    <= det_in;
            s2    <= s1;
            s3    <= s2;
            hit_q <= s2 & ~s3 & {NUM_CHANNELS{run}};
            run_q <= run;
        end
    end

`ifdef TAGGER_DEADTIME_EN
    localparam int CW = clog2(DEADTIME_CYCLES + 1);

    ch_state_t     state      [NUM_CHANNELS];
    ch_state_t     state_next [NUM_CHANNELS];
    logic [CW-1:0] cnt        [NUM_CHANNELS];
    logic [CW-1:0] cnt_next   [NUM_CHANNELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state[i] <= CH_READY;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    // The hit cycle itself counts as the first holdoff cycle, so successive tags
    // on one channel are at least DEADTIME_CYCLES apart.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            if (!run) begin
                state_next[i] = CH_READY;
                cnt_next[i]   = '0;
            end else begin
                case (state[i])
                    CH_READY: begin
                        if (hit_q[i]) begin
                            hit[i]        = 1'b1;
                            state_next[i] = CH_HOLDOFF;
                            cnt_next[i]   = CW'(DEADTIME_CYCLES - 1);
                        end
                    end
                    CH_HOLDOFF: begin
                        cnt_next[i] = cnt[i] - CW'(1);
                        if (cnt[i] <= CW'(1)) begin
                            state_next[i] = CH_READY;
                            cnt_next[i]   = '0;
                        end
                    end
                    default: state_next[i] = CH_READY;
                endcase
            end
        end
    end
`else
    assign hit = hit_q & {NUM_CHANNELS{run}};
`endif

    logic          any_hit;
    logic          full;
    logic          pop;
    logic          drop;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] rd_data;

    assign any_hit = |hit;
    assign full    = (fifo_level == LW'(FIFO_DEPTH));
    assign pop     = m_valid & m_ready;
    assign drop    = any_hit & full & ~pop;
    assign wr_data = {hit, timestamp};

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (run && !run_q) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_CNT_WIDTH'(1);
        end
    end

    tag_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (any_hit),
        .wr_data (wr_data),
        .rd_en   (m_ready),
        .rd_data (rd_data),
        .level   (fifo_level)
    );

    assign m_valid     = (fifo_level != '0);
    assign m_mask      = rd_data[MASK_LSB +: NUM_CHANNELS];
    assign m_timestamp = rd_data[ENTRY_TS_LSB +: TS_WIDTH];

endmodule

// File: tb/tb_photon_event_tagger.sv
// Directed bench for photon_event_tagger; holdoff expectations follow TAGGER_DEADTIME_EN.
module tb_photon_event_tagger;

    logic        clk;
    logic        reset;
    logic        run;
    logic [63:0] timestamp;
    logic [3:0]  det_in;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_mask;
    logic [63:0] m_timestamp;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    photon_event_tagger dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .timestamp   (timestamp),
        .det_in      (det_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_mask      (m_mask),
        .m_timestamp (m_timestamp),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; afterwards the timestamp follows the upstream generator.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (reset) timestamp = '0;
            else if (run) timestamp = timestamp + 64'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ts(input logic [63:0] target);
        for (int k = 0; k < 400 && timestamp != target; k++) tick(1);
        if (timestamp != target) begin
            errors++;
            $error("FAIL wait_ts observed=%0d expected=%0d", timestamp, target);
        end
    endtask

    task automatic pulse(input logic [3:0] mask, input int high, input int low);
        det_in = mask;
        tick(high);
        det_in = '0;
        tick(low);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; det_in = '0; m_ready = 1'b0; timestamp = '0;
        tick(2);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_mask", 64'(m_mask), 64'd0);
        chk("rst_ts", m_timestamp, 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        // single channel, 3 cycles high
        reset = 1'b0; run = 1'b1;
        wait_ts(64'd20);
        pulse(4'b0010, 3, 0);
        chk("s1_valid_hitcycle", 64'(m_valid), 64'd0);
        tick(1);
        chk("s1_valid", 64'(m_valid), 64'd1);
        chk("s1_mask", 64'(m_mask), 64'b0010);
        chk("s1_ts", m_timestamp, 64'd23);
        chk("s1_level", 64'(fifo_level), 64'd1);
        chk("s1_drop", 64'(drop_count), 64'd0);
        m_ready = 1'b1; tick(1); m_ready = 1'b0;
        chk("s1_pop_level", 64'(fifo_level), 64'd0);

        // two channels in the same cycle
        wait_ts(64'd40);
        pulse(4'b1001, 2, 2);
        chk("s2_mask", 64'(m_mask), 64'b1001);
        chk("s2_ts", m_timestamp, 64'd43);
        chk("s2_level", 64'(fifo_level), 64'd1);
        m_ready = 1'b1; tick(1); m_ready = 1'b0;

        // overflow: 20 pulses into 16 slots
        wait_ts(64'd60);
        for (int p = 0; p < 20; p++) pulse(4'b0100, 2, 3);
        chk("s3_level", 64'(fifo_level), 64'd16);
        chk("s3_drop", 64'(drop_count), 64'd4);
        chk("s3_head_ts", m_timestamp, 64'd63);
        chk("s3_head_mask", 64'(m_mask), 64'b0100);
        m_ready = 1'b1;
        for (int p = 0; p < 16; p++) begin
            chk($sformatf("s3_drain_ts%0d", p), m_timestamp, 64'd63 + 64'(5 * p));
            tick(1);
        end
        m_ready = 1'b0;
        chk("s3_empty", 64'(fifo_level), 64'd0);

        // full FIFO with a pop in the hit cycle
        wait_ts(64'd200);
        for (int p = 0; p < 16; p++) pulse(4'b0100, 2, 3);
        chk("s4_full", 64'(fifo_level), 64'd16);
        pulse(4'b0100, 2, 1);
        m_ready = 1'b1; tick(1); m_ready = 1'b0;
        chk("s4_level", 64'(fifo_level), 64'd16);
        chk("s4_drop", 64'(drop_count), 64'd4);
        m_ready = 1'b1;
        for (int p = 0; p < 16; p++) begin
            chk($sformatf("s4_drain_ts%0d", p), m_timestamp, 64'd208 + 64'(5 * p));
            tick(1);
        end
        m_ready = 1'b0;

        // run low: no new entries, existing ones still drain
        wait_ts(64'd350);
        pulse(4'b0100, 2, 3);
        pulse(4'b0100, 2, 3);
        run = 1'b0;
        pulse(4'b1111, 2, 3);
        pulse(4'b1111, 2, 3);
        chk("s5_level", 64'(fifo_level), 64'd2);
        m_ready = 1'b1;
        chk("s5_ts0", m_timestamp, 64'd353);
        tick(1);
        chk("s5_ts1", m_timestamp, 64'd358);
        tick(1);
        chk("s5_empty", 64'(fifo_level), 64'd0);
        tick(1);
        chk("s5_pop_empty_level", 64'(fifo_level), 64'd0);
        chk("s5_pop_empty_valid", 64'(m_valid), 64'd0);
        m_ready = 1'b0;
        chk("s5_drop_kept", 64'(drop_count), 64'd4);
        run = 1'b1;
        tick(1);
        chk("s5_drop_cleared", 64'(drop_count), 64'd0);

        // reset mid-stream
        pulse(4'b0001, 2, 3);
        chk("s6_level", 64'(fifo_level), 64'd1);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("s6_level_rst", 64'(fifo_level), 64'd0);
        chk("s6_valid_rst", 64'(m_valid), 64'd0);
        chk("s6_mask_rst", 64'(m_mask), 64'd0);
        chk("s6_ts_rst", m_timestamp, 64'd0);

        // channel 0 pulses every 4 cycles
        wait_ts(64'd10);
        for (int p = 0; p < 4; p++) pulse(4'b0001, 2, 2);
        m_ready = 1'b1;
`ifdef TAGGER_DEADTIME_EN
        chk("s7_level", 64'(fifo_level), 64'd2);
        chk("s7_ts0", m_timestamp, 64'd13);
        tick(1);
        chk("s7_ts1", m_timestamp, 64'd21);
        tick(1);
`else
        chk("s7_level", 64'(fifo_level), 64'd4);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("s7_ts%0d", p), m_timestamp, 64'd13 + 64'(4 * p));
            tick(1);
        end
`endif
        m_ready = 1'b0;
        chk("s7_empty", 64'(fifo_level), 64'd0);

        // reset during holdoff re-arms the channel
        wait_ts(64'd40);
        pulse(4'b0001, 2, 2);
        chk("s8_tagged", m_timestamp, 64'd43);
        reset = 1'b1; tick(1); reset = 1'b0;
        pulse(4'b0001, 2, 2);
        chk("s8_level", 64'(fifo_level), 64'd1);
        chk("s8_mask", 64'(m_mask), 64'b0001);
        chk("s8_ts", m_timestamp, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
